vec_scalar_divider: RTL and testbench
=====================================

Name: vec_scalar_divider

Overview:
- Parametrised successor to the fixed two-lane 16-bit divider.
- Divides LANES signed fixed-point elements of a vector by one shared scalar, e.g. row normalisation in the ZF inverse (adj/det).
- One shared iterative restoring-division controller drives LANES identical lane datapaths.
- Adds saturation, per-lane overflow flags, a divide-by-zero flag and clock-enable stalling.

Parameters:
- LANES, 2, number of vector elements divided in parallel (>=1).
- WIDTH, 16, bit width of each element, divisor and result (>=4).
- FRAC, 8, fractional bits of the signed Q format shared by operands and result (0..WIDTH-1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  clock enable; low freezes all state.
- accept_in  in  1  start request; operands are sampled when accept_in=1, accept_out=1, enable=1.
- accept_out  out  1  block can take new operands (IDLE or DONE).
- ready_out  out  1  res/ovf/dz valid.
- vec  in  LANES*WIDTH  dividend lanes; lane i = vec[i*WIDTH +: WIDTH].
- el  in  WIDTH  shared signed divisor.
- res  out  LANES*WIDTH  quotient lanes, same packing as vec.
- ovf  out  LANES  per-lane saturation flag.
- dz  out  1  divisor was zero.

Behaviour:
- Reset: asynchronous, active-low, fixed. While reset_n=0: state=IDLE, accept_out=1, ready_out=0, res=0, ovf=0, dz=0, counter=0.
- Reset mid-operation aborts the divide; no partial result is ever presented.
- ITER = WIDTH+FRAC.
- FSM states:
  - IDLE: accept_out=1. On a start request, capture |vec_i|<<FRAC, |el|, the sign of each lane (sign(vec_i) XOR sign(el)), and el==0. Go to CALC, counter=0, accept_out=0, ready_out=0.
  - CALC: one restoring step per enabled cycle on every lane (shift the partial remainder, trial-subtract |el|, set the quotient bit). Counter increments; after step ITER-1 go to FIX.
  - FIX: one cycle. For each lane, saturate the magnitude, apply the sign, and register res/ovf/dz. Go to DONE.
  - DONE: ready_out=1, accept_out=1; outputs hold. A new start request goes to CALC with the same capture as IDLE, and ready_out drops on that edge.
- Latency: ready_out rises ITER+2 enabled clock edges after the accepting edge (26 with the defaults).
- Sign-magnitude: magnitudes are held in WIDTH+1 bits so -2^(WIDTH-1) is exact.
- Saturation:
  - Positive lane with quotient magnitude > 2^(WIDTH-1)-1 gives 0x7FF..F.
  - Negative lane with magnitude > 2^(WIDTH-1) gives 0x800..0.
  - Either case sets ovf[i]=1.
- Rounding: truncation toward zero.
- Divide by zero (el==0): dz=1 and every ovf bit=1. Lane result is max positive if vec_i >= 0, else max negative. The full ITER cycles still elapse, so latency is constant.
- enable=0: the FSM, counter, datapaths and outputs all hold, and start requests are ignored.
- accept_in while busy (CALC/FIX) is ignored; there is no queue.
- Operands are needed only on the accepting edge.

Decomposition:
- Shared package: state encoding (IDLE, CALC, FIX, DONE), an ITER constant function, and a saturation-limit helper.
- Natural sub-module: div_lane.
  - Holds one lane's remainder/quotient registers, the step datapath and the FIX saturation.
  - Is instantiated LANES times by a generate loop.
  - Is driven by shared load, step and fix strobes from the top-level FSM.

Test Plan (LANES=2, WIDTH=16, FRAC=8):
- Basic divide: vec={0x0400,0x0300}, el=0x0200 (2.0), accept_in pulse -> after 26 edges ready_out=1, res={0x0200,0x0180}, ovf=0, dz=0.
- Signed: vec={0xFC00,0x0400}, el=0xFE00 -> res={0x0200,0xFE00}. Also vec lane=0x8000, el=0x0100 -> 0x8000, ovf=0.
- Overflow: vec={0x7F00,0x8100}, el=0x0001 -> res={0x7FFF,0x8000}, ovf=2'b11, dz=0.
- Divide by zero: vec={0x0100,0xFF00}, el=0 -> res={0x7FFF,0x8000}, dz=1, ovf=2'b11, latency still 26.
- Enable stall: drop enable for 5 cycles mid-CALC -> ready_out at edge 31 with the correct result; accept_in pulses during CALC are ignored.
- Reset mid-CALC, then back-to-back starts: reset at cycle 10 -> outputs 0, accept_out=1. Then a start from DONE with new operands -> ready_out falls next edge and the new result arrives 26 edges later.

Source files
------------

// File: rtl/vec_scalar_divider_pkg.sv
// rtl/vec_scalar_divider_pkg.sv - shared state encoding and helpers for the vector/scalar divider
package vec_scalar_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of restoring steps: the dividend is |vec| scaled by 2^FRAC.
  function automatic int iter_count(input int width, input int frac);
    return width + frac;
  endfunction

  // Largest representable quotient magnitude for the given sign.
  // Negative results reach one further than positive ones (-2^(W-1)).
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    logic [63:0] lim;
    lim = 64'd1 << (width - 1);
    if (!neg) begin
      lim = lim - 64'd1;
    end
    return lim;
  endfunction

endpackage

// File: rtl/vec_scalar_divider_div_lane.sv
// rtl/vec_scalar_divider_div_lane.sv - one lane of restoring division with saturation
module div_lane
  import vec_scalar_divider_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] vec,
  input  logic             el_sign,
  input  logic [WIDTH:0]   div_mag,
  input  logic             div_zero,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int ITER = iter_count(WIDTH, FRAC);

  logic [WIDTH:0]   rem;
  logic [ITER-1:0]  quo;
  logic             neg;

  logic [WIDTH:0]   vec_ext;
  logic [WIDTH:0]   vec_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [63:0]      quo_ext;
  logic             over;
  logic [WIDTH-1:0] quo_lo;
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] max_neg;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  // Operand magnitude, trial subtraction and saturated result for this lane.
  always_comb begin
    vec_ext  = {vec[WIDTH-1], vec};
    vec_mag  = vec[WIDTH-1] ? (~vec_ext + 1'b1) : vec_ext;
    rem_sh   = {rem[WIDTH-1:0], quo[ITER-1]};
    diff     = {1'b0, rem_sh} - {1'b0, div_mag};
    quo_ext  = 64'(quo);
    over     = quo_ext > sat_limit(WIDTH, neg);
    quo_lo   = quo[WIDTH-1:0];
    max_pos  = {1'b0, {(WIDTH-1){1'b1}}};
    max_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    res_next = neg ? (~quo_lo + 1'b1) : quo_lo;
    ovf_next = 1'b0;
    if (div_zero || over) begin
      res_next = neg ? max_neg : max_pos;
      ovf_next = 1'b1;
    end
  end

  // Remainder/quotient shift register: load the scaled dividend, then one step per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      neg <= 1'b0;
    end else if (load) begin
      rem <= '0;
      quo <= ITER'(vec_mag) << FRAC;
      neg <= vec[WIDTH-1] ^ el_sign;
    end else if (step) begin
      if (!diff[WIDTH+1]) begin
        rem <= diff[WIDTH:0];
        quo <= {quo[ITER-2:0], 1'b1};
      end else begin
        rem <= rem_sh;
        quo <= {quo[ITER-2:0], 1'b0};
      end
    end
  end

  // Result registers only change on the fix strobe so outputs hold through a new divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (fix) begin
      res <= res_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/vec_scalar_divider.sv
// rtl/vec_scalar_divider.sv - divides LANES signed fixed-point elements by one shared scalar
module vec_scalar_divider
  import vec_scalar_divider_pkg::*;
#(
  parameter int LANES = 2,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   accept_in,
  output logic                   accept_out,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] vec,
  input  logic [WIDTH-1:0]       el,
  output logic [LANES*WIDTH-1:0] res,
  output logic [LANES-1:0]       ovf,
  output logic                   dz
);

  localparam int ITER = iter_count(WIDTH, FRAC);
  localparam int CW   = $clog2(ITER + 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   counter;
  logic [WIDTH:0]  div_mag;
  logic            div_zero;

  logic            load;
  logic            step;
  logic            fix;
  logic [WIDTH:0]  el_ext;
  logic [WIDTH:0]  el_mag;

  assign accept_out = (state == ST_IDLE) || (state == ST_DONE);
  assign ready_out  = (state == ST_DONE);

  // Divisor magnitude is shared by every lane.
  always_comb begin
    el_ext = {el[WIDTH-1], el};
    el_mag = el[WIDTH-1] ? (~el_ext + 1'b1) : el_ext;
  end

  // Next-state and lane strobes; nothing moves while enable is low.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_in) begin
            load       = 1'b1;
            next_state = ST_CALC;
          end
        end
        ST_CALC: begin
          step = 1'b1;
          if (counter == CW'(ITER - 1)) begin
            next_state = ST_FIX;
          end
        end
        ST_FIX: begin
          fix        = 1'b1;
          next_state = ST_DONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Step counter: cleared on capture, advanced once per restoring step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (load) begin
      counter <= '0;
    end else if (step) begin
      counter <= counter + CW'(1);
    end
  end

  // Captured divisor and its zero flag; dz is published only at fix time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_mag  <= '0;
      div_zero <= 1'b0;
      dz       <= 1'b0;
    end else begin
      if (load) begin
        div_mag  <= el_mag;
        div_zero <= (el == '0);
      end
      if (fix) begin
        dz <= div_zero;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    div_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_lane (
      .clk     (clk),
      .rst_n   (reset_n),
      .load    (load),
      .step    (step),
      .fix     (fix),
      .vec     (vec[i*WIDTH +: WIDTH]),
      .el_sign (el[WIDTH-1]),
      .div_mag (div_mag),
      .div_zero(div_zero),
      .res     (res[i*WIDTH +: WIDTH]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_vec_scalar_divider.sv
// tb/tb_vec_scalar_divider.sv - self-checking bench for vec_scalar_divider
module tb_vec_scalar_divider;

  localparam int LANES = 2;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int LAT   = 26;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   enable;
  logic                   accept_in;
  logic                   accept_out;
  logic                   ready_out;
  logic [LANES*WIDTH-1:0] vec;
  logic [WIDTH-1:0]       el;
  logic [LANES*WIDTH-1:0] res;
  logic [LANES-1:0]       ovf;
  logic                   dz;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_scalar_divider #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .accept_in (accept_in),
    .accept_out(accept_out),
    .ready_out (ready_out),
    .vec       (vec),
    .el        (el),
    .res       (res),
    .ovf       (ovf),
    .dz        (dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued quotient a/b in Q8, truncated toward zero, then clamped.
  function automatic void model_lane(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output logic o);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      o = 1'b1;
      r = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      q = (sa * 256) / sb;
      if (q > 32767) begin
        o = 1'b1;
        r = 16'h7FFF;
      end else if (q < -32768) begin
        o = 1'b1;
        r = 16'h8000;
      end else begin
        o = 1'b0;
        r = q[15:0];
      end
    end
  endfunction

  task automatic run_div(input string tag, input logic [31:0] v, input logic [15:0] e,
                         input int stall_at, input int stall_len, input int pulse_at);
    logic [31:0] exp_res;
    logic [1:0]  exp_ovf;
    logic [15:0] r;
    logic        o;
    int          n;
    for (int i = 0; i < LANES; i++) begin
      model_lane(v[i*16 +: 16], e, r, o);
      exp_res[i*16 +: 16] = r;
      exp_ovf[i]          = o;
    end
    vec       = v;
    el        = e;
    accept_in = 1'b1;
    @(posedge clk);
    #1;
    n         = 1;
    accept_in = 1'b0;
    vec       = $urandom;
    el        = 16'($urandom);
    check({tag, "/busy"}, {30'd0, accept_out, ready_out}, 32'd0);
    while (!ready_out && n < 200) begin
      if (n == stall_at) enable = 1'b0;
      if (n == stall_at + stall_len) enable = 1'b1;
      accept_in = (n == pulse_at) || !enable;
      @(posedge clk);
      #1;
      n++;
    end
    accept_in = 1'b0;
    enable    = 1'b1;
    check({tag, "/latency"}, 32'(n), 32'(LAT + stall_len));
    check({tag, "/res"}, res, exp_res);
    check({tag, "/ovf"}, {30'd0, ovf}, {30'd0, exp_ovf});
    check({tag, "/dz"}, {31'd0, dz}, {31'd0, (e == 16'd0)});
    check({tag, "/accept"}, {31'd0, accept_out}, 32'd1);
  endtask

  initial begin
    logic        seen_ready;
    logic [15:0] re;
    int          mode;

    reset_n   = 1'b0;
    enable    = 1'b1;
    accept_in = 1'b0;
    vec       = '0;
    el        = '0;
    #1;
    check("reset/res", res, 32'd0);
    check("reset/flags", {29'd0, ovf, dz}, 32'd0);
    check("reset/hs", {30'd0, accept_out, ready_out}, 32'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_div("basic",    {16'h0400, 16'h0300}, 16'h0200, -1, 0, -1);
    run_div("signed",   {16'hFC00, 16'h0400}, 16'hFE00, -1, 0, -1);
    run_div("minneg",   {16'h8000, 16'h0100}, 16'h0100, -1, 0, -1);
    run_div("overflow", {16'h7F00, 16'h8100}, 16'h0001, -1, 0, -1);
    run_div("divzero",  {16'h0100, 16'hFF00}, 16'h0000, -1, 0, -1);
    run_div("stall",    {16'h1234, 16'hE000}, 16'h0300, 8, 5, 4);

    // Abort a divide with reset and confirm nothing partial ever appears.
    vec       = {16'h0700, 16'h0500};
    el        = 16'h0100;
    accept_in = 1'b1;
    @(posedge clk);
    #1;
    accept_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("midreset/res", res, 32'd0);
    check("midreset/flags", {29'd0, ovf, dz}, 32'd0);
    check("midreset/hs", {30'd0, accept_out, ready_out}, 32'd2);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      seen_ready = seen_ready | ready_out;
    end
    check("midreset/noresult", {31'd0, seen_ready}, 32'd0);

    run_div("after_reset", {16'h0300, 16'hFD00}, 16'h0180, -1, 0, -1);
    run_div("b2b",         {16'h0010, 16'h7FFF}, 16'hFFFF, -1, 0, -1);

    for (int k = 0; k < 10; k++) begin
      mode = int'($urandom_range(0, 3));
      re   = 16'($urandom);
      if (mode == 0) re = 16'h0000;
      else if (mode == 1) re = 16'($urandom_range(1, 15)) ^ ({16{re[15]}});
      run_div($sformatf("rand%0d", k), $urandom, re, -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
